// File: rtl/alu_mul_seq.sv
// Iterative shift-and-add multiplier that borrows the shared EX-stage ALU.
// Produces the low 32 bits of an unsigned a*b, one ALU operation per cycle.
module alu_mul_seq #(
  parameter logic [2:0] F_ADD = 3'b010,
  parameter logic [2:0] F_SHL = 3'b111
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [31:0] alu_y,
  output logic        alu_own,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [2:0]  alu_f,
  output logic        busy,
  output logic        done,
  output logic [31:0] product
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ADD   = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t      state;
  state_t      state_next;
  logic [31:0] ma;
  logic [31:0] mb;
  logic [31:0] acc;
  logic        accept;

  // A new request is only taken when the ALU is not already borrowed.
  assign accept = start && ((state == IDLE) || (state == DONE));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    alu_own    = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    alu_a      = 32'd0;
    alu_b      = 32'd0;
    alu_f      = 3'b000;
    case (state)
      IDLE: begin
        if (accept) begin
          state_next = (b == 32'd0) ? DONE : ADD;
        end
      end
      ADD: begin
        alu_own    = 1'b1;
        busy       = 1'b1;
        alu_f      = F_ADD;
        alu_a      = acc;
        alu_b      = ma;
        state_next = (mb[31:1] == 31'd0) ? DONE : SHIFT;
      end
      SHIFT: begin
        alu_own    = 1'b1;
        busy       = 1'b1;
        alu_f      = F_SHL;
        alu_a      = ma;
        alu_b      = 32'd1;
        state_next = ADD;
      end
      DONE: begin
        done = 1'b1;
        if (accept) begin
          state_next = (b == 32'd0) ? DONE : ADD;
        end else begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // The ALU result is captured into acc only when the current multiplier bit is set.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ma  <= 32'd0;
      mb  <= 32'd0;
      acc <= 32'd0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (accept) begin
            ma  <= a;
            mb  <= b;
            acc <= 32'd0;
          end
        end
        ADD: begin
          if (mb[0]) begin
            acc <= alu_y;
          end
        end
        SHIFT: begin
          ma <= alu_y;
          mb <= {1'b0, mb[31:1]};
        end
        default: begin
          ma <= ma;
        end
      endcase
    end
  end

  assign product = acc;

endmodule

// File: tb/tb_alu_mul_seq.sv
// Scoreboard bench for alu_mul_seq: directed cases plus randomized traffic,
// with a behavioural ALU and an arithmetic reference model.
module tb_alu_mul_seq;

  localparam logic [2:0] F_ADD = 3'b010;
  localparam logic [2:0] F_SHL = 3'b111;

  logic        clk;
  logic        reset_n;
  logic        start;
  logic [31:0] a;
  logic [31:0] b;
  logic [31:0] alu_y;
  logic        alu_own;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [2:0]  alu_f;
  logic        busy;
  logic        done;
  logic [31:0] product;

  typedef struct {
    logic [31:0] prod;
    int          n;
    int          done_e;
  } exp_t;

  exp_t        q[$];
  int          e;
  int          last_done_e;
  logic [31:0] held_prod;
  int          checks;
  int          failures;

  alu_mul_seq #(.F_ADD(F_ADD), .F_SHL(F_SHL)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (start),
    .a       (a),
    .b       (b),
    .alu_y   (alu_y),
    .alu_own (alu_own),
    .alu_a   (alu_a),
    .alu_b   (alu_b),
    .alu_f   (alu_f),
    .busy    (busy),
    .done    (done),
    .product (product)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) e = e + 1;

  // Stand-in for the shared EX-stage ALU.
  always_comb begin
    alu_y = 32'd0;
    if (alu_f == F_ADD) alu_y = alu_a + alu_b;
    else if (alu_f == F_SHL) alu_y = alu_a << alu_b[4:0];
  end

  task automatic check32(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at edge %0d", name, got, want, e);
    end
  endtask

  function automatic int latency(input logic [31:0] mb);
    int k;
    k = -1;
    for (int i = 0; i < 32; i++) if (mb[i]) k = i;
    return (k < 0) ? 1 : 2 * k + 2;
  endfunction

  // Present a request for one cycle; the model decides whether it is accepted.
  task automatic issue(input logic [31:0] xa, input logic [31:0] xb);
    exp_t it;
    start = 1'b1;
    a     = xa;
    b     = xb;
    if (e >= last_done_e) begin
      it.prod     = xa * xb;
      it.n        = e;
      it.done_e   = e + latency(xb);
      last_done_e = it.done_e;
      q.push_back(it);
    end
    @(posedge clk);
    #1;
    start = 1'b0;
    a     = $urandom;
    b     = $urandom;
  endtask

  task automatic wait_ready();
    int g;
    g = 0;
    while (e < last_done_e && g < 200) begin
      @(posedge clk);
      #1;
      g++;
    end
  endtask

  task automatic gap(input int cycles);
    repeat (cycles) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic reset_now(input int hold);
    reset_n = 1'b0;
    start   = 1'b0;
    #1;
    check32("async_reset_ctrl", {29'd0, busy, done, alu_own}, 32'd0);
    check32("async_reset_alu_a", alu_a, 32'd0);
    check32("async_reset_alu_b", alu_b, 32'd0);
    check32("async_reset_alu_f", {29'd0, alu_f}, 32'd0);
    check32("async_reset_product", product, 32'd0);
    q.delete();
    held_prod   = 32'd0;
    last_done_e = 0;
    repeat (hold) @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  // Monitor: checks ownership window, idle outputs, held product and done responses.
  always @(negedge clk) begin
    if (reset_n) begin
      logic exp_busy;
      if (q.size() > 0 && e > q[0].done_e) begin
        checks++;
        failures++;
        $display("[TB] FAIL done_timeout: no done by edge %0d expected at %0d", e, q[0].done_e);
        void'(q.pop_front());
      end
      exp_busy = (q.size() > 0) && (e > q[0].n) && (e < q[0].done_e);
      check32("busy_own", {30'd0, busy, alu_own}, {30'd0, exp_busy, exp_busy});
      if (!exp_busy) begin
        check32("idle_alu_a", alu_a, 32'd0);
        check32("idle_alu_b", alu_b, 32'd0);
        check32("idle_alu_f", {29'd0, alu_f}, 32'd0);
      end
      if (done) begin
        if (q.size() == 0) begin
          checks++;
          failures++;
          $display("[TB] FAIL spurious_done: got done=1 expected none at edge %0d", e);
        end else begin
          check32("done_cycle", e, q[0].done_e);
          check32("product", product, q[0].prod);
          held_prod = q[0].prod;
          void'(q.pop_front());
        end
      end else if (q.size() > 0 && e == q[0].done_e) begin
        checks++;
        failures++;
        $display("[TB] FAIL missing_done: got done=0 expected 1 at edge %0d", e);
        void'(q.pop_front());
      end else if (!exp_busy) begin
        check32("held_product", product, held_prod);
      end
    end
  end

  initial begin
    int g;
    e           = 0;
    last_done_e = 0;
    held_prod   = 32'd0;
    checks      = 0;
    failures    = 0;
    reset_n     = 1'b1;
    start       = 1'b0;
    a           = 32'd0;
    b           = 32'd0;
    #2;
    reset_now(2);
    gap(1);

    issue(32'd3, 32'd5);
    wait_ready();
    gap(2);

    issue(32'h1234, 32'd0);
    wait_ready();
    gap(2);

    issue(32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_ready();
    gap(2);

    issue(32'd7, 32'd9);
    gap(2);
    issue(32'd2, 32'd2);
    wait_ready();
    gap(2);

    issue(32'd6, 32'd6);
    wait_ready();
    issue(32'd4, 32'd4);
    wait_ready();
    gap(2);

    issue(32'hFFFF, 32'hFFFF);
    gap(3);
    reset_now(2);
    gap(1);
    issue(32'd2, 32'd3);
    wait_ready();
    gap(2);

    repeat (60) begin
      logic [31:0] ra;
      logic [31:0] rb;
      ra = $urandom;
      rb = $urandom >> $urandom_range(0, 31);
      if ($urandom_range(0, 7) == 0) rb = 32'd0;
      if ($urandom_range(0, 2) != 0) begin
        wait_ready();
        gap($urandom_range(0, 2));
      end
      issue(ra, rb);
    end

    g = 0;
    while (q.size() > 0 && g < 200) begin
      @(posedge clk);
      #1;
      g++;
    end
    if (q.size() > 0) begin
      checks++;
      failures++;
      $display("[TB] FAIL drain: got %0d pending results expected 0", q.size());
    end
    gap(2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
